// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file (regfile_mp).
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG  = 0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set on load issue, cleared by flush or writeback.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic             flush,
  input  logic             wa_en,
  input  logic [AW-1:0]    wa_addr,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREGS; i++) begin
      // A same-cycle issue beats flush and writeback: the new load is still in flight.
      if (iss_en && iss_addr == AW'(i)) begin
        busy_d[i] = 1'b1;
      end else if (flush) begin
        busy_d[i] = 1'b0;
      end else if ((wb_en && wb_addr == AW'(i)) || (wa_en && wa_addr == AW'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational reads, two write ports, load scoreboard.
// Build option: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NREAD = 2,
  parameter int AW    = clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wa_en,
  input  logic [AW-1:0]         wa_addr,
  input  logic [XLEN-1:0]       wa_data,
  input  logic                  wb_en,
  input  logic [AW-1:0]         wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  input  logic                  flush,
  output logic [NREGS-1:0]      busy_vec
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic            wa_hit;
  logic            wb_hit;

  assign wa_hit = wa_en && (wa_addr != ZERO_ADDR);
  assign wb_hit = wb_en && (wb_addr != ZERO_ADDR);

  // Port B is applied first so port A (younger instruction) wins a same-address collision.
  always_comb begin
    mem_d = mem_q;
    if (wb_hit) mem_d[wb_addr] = wb_data;
    if (wa_hit) mem_d[wa_addr] = wa_data;
    mem_d[ZERO_REG] = '0;
  end

  // NOTE: the array must read as zero after reset, so it is built from resettable flops, not RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .wa_en    (wa_en),
    .wa_addr  (wa_addr),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .busy_vec (busy_vec)
  );

  logic [AW-1:0] rd_addr_a [NREAD];

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NREAD; k++) begin
      rd_addr_a[k] = rd_addr[k*AW +: AW];
      rd_data[k*XLEN +: XLEN] = mem_q[rd_addr_a[k]];
      rd_busy[k]              = busy_vec[rd_addr_a[k]];
`ifdef REGFILE_BYPASS_EN
      // A forwarded write satisfies the pending load, so the busy flag is masked too.
      if (wa_hit && wa_addr == rd_addr_a[k]) begin
        rd_data[k*XLEN +: XLEN] = wa_data;
        rd_busy[k]              = 1'b0;
      end else if (wb_hit && wb_addr == rd_addr_a[k]) begin
        rd_data[k*XLEN +: XLEN] = wb_data;
        rd_busy[k]              = 1'b0;
      end
`endif
      if (rd_addr_a[k] == ZERO_ADDR) begin
        rd_data[k*XLEN +: XLEN] = '0;
        rd_busy[k]              = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic against a model.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  localparam int WXLEN  = 64;
  localparam int WNREGS = 64;
  localparam int WNREAD = 4;
  localparam int WAW    = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  wa_en, wb_en, iss_en, flush;
  logic [AW-1:0]         wa_addr, wb_addr, iss_addr;
  logic [XLEN-1:0]       wa_data, wb_data;
  logic [NREGS-1:0]      busy_vec;

  logic [WNREAD*WAW-1:0]   w_rd_addr;
  logic [WNREAD*WXLEN-1:0] w_rd_data;
  logic [WNREAD-1:0]       w_rd_busy;
  logic                    w_wa_en, w_wb_en, w_iss_en, w_flush;
  logic [WAW-1:0]          w_wa_addr, w_wb_addr, w_iss_addr;
  logic [WXLEN-1:0]        w_wa_data, w_wb_data;
  logic [WNREGS-1:0]       w_busy_vec;

  regfile_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec)
  );

  regfile_mp #(.XLEN(WXLEN), .NREGS(WNREGS), .NREAD(WNREAD)) dut_w (
    .clk(clk), .rst(rst), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
    .wa_en(w_wa_en), .wa_addr(w_wa_addr), .wa_data(w_wa_data),
    .wb_en(w_wb_en), .wb_addr(w_wb_addr), .wb_data(w_wb_data),
    .iss_en(w_iss_en), .iss_addr(w_iss_addr), .flush(w_flush), .busy_vec(w_busy_vec)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: architectural register values and pending-load flags.
  logic [XLEN-1:0] m_reg  [NREGS];
  bit              m_busy [NREGS];

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wa_en && wa_addr == a) return wa_data;
    if (wb_en && wb_addr == a) return wb_data;
`endif
    return m_reg[a];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if ((wa_en && wa_addr == a) || (wb_en && wb_addr == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic logic [NREGS-1:0] exp_vec();
    logic [NREGS-1:0] v;
    for (int i = 0; i < NREGS; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Advance one clock, applying the architectural rules to the model first.
  task automatic tick();
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        bit wr;
        wr = (wa_en && wa_addr == i) || (wb_en && wb_addr == i);
        if (iss_en && iss_addr == i) m_busy[i] = 1'b1;
        else if (flush || wr)        m_busy[i] = 1'b0;
      end
      if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
      if (wa_en && wa_addr != 0) m_reg[wa_addr] = wa_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b1; wa_en = 0; wb_en = 0; iss_en = 0; flush = 0;
    wa_addr = '0; wb_addr = '0; iss_addr = '0; wa_data = '0; wb_data = '0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic test_reset();
    idle();
    rd_addr = '0;
    w_rd_addr = '0; w_wa_en = 0; w_wb_en = 0; w_iss_en = 0; w_flush = 0;
    w_wa_addr = '0; w_wb_addr = '0; w_iss_addr = '0; w_wa_data = '0; w_wb_data = '0;
    rst = 1'b0; wa_en = 1; wa_addr = 5; wa_data = 32'hDEAD_BEEF;
    tick();
    tick();
    idle();
    set_rd(0, 5);
    @(negedge clk);
    checks++;
    if (rd_data[XLEN-1:0] !== 32'h0) begin
      errors++; $display("FAIL reset_x5: got %h want 00000000", rd_data[XLEN-1:0]);
    end
    checks++;
    if (busy_vec !== '0) begin
      errors++; $display("FAIL reset_busy_vec: got %h want 0", busy_vec);
    end
    checks++;
    if (rd_busy !== '0) begin
      errors++; $display("FAIL reset_rd_busy: got %b want 0", rd_busy);
    end
    tick();
  endtask

  task automatic test_basic();
    idle();
    wa_en = 1; wa_addr = 3; wa_data = 32'h1234_5678;
    set_rd(0, 3);
    @(negedge clk);
    checks++;
    if (rd_data[XLEN-1:0] !== exp_data(3)) begin
      errors++; $display("FAIL basic_same_cycle: got %h want %h", rd_data[XLEN-1:0], exp_data(3));
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (rd_data[XLEN-1:0] !== 32'h1234_5678) begin
      errors++; $display("FAIL basic_x3: got %h want 12345678", rd_data[XLEN-1:0]);
    end
    wa_en = 1; wa_addr = 0; wa_data = 32'hFFFF_FFFF;
    set_rd(0, 0);
    @(negedge clk);
    checks++;
    if (rd_data[XLEN-1:0] !== 32'h0) begin
      errors++; $display("FAIL x0_during_write: got %h want 00000000", rd_data[XLEN-1:0]);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (rd_data[XLEN-1:0] !== 32'h0) begin
      errors++; $display("FAIL x0_after_write: got %h want 00000000", rd_data[XLEN-1:0]);
    end
  endtask

  task automatic test_collision();
    idle();
    wa_en = 1; wa_addr = 7; wa_data = 32'hAAAA_0000;
    wb_en = 1; wb_addr = 7; wb_data = 32'h0000_BBBB;
    tick();
    idle();
    set_rd(1, 7);
    @(negedge clk);
    checks++;
    if (rd_data[XLEN +: XLEN] !== 32'hAAAA_0000) begin
      errors++; $display("FAIL collision_x7: got %h want aaaa0000", rd_data[XLEN +: XLEN]);
    end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] want_d;
    logic            want_b;
    idle();
    wa_en = 1; wa_addr = 9; wa_data = 32'h11;
    tick();
    idle();
    iss_en = 1; iss_addr = 9;
    tick();
    idle();
    wb_en = 1; wb_addr = 9; wb_data = 32'h55;
    set_rd(1, 9);
`ifdef REGFILE_BYPASS_EN
    want_d = 32'h55; want_b = 1'b0;
`else
    want_d = 32'h11; want_b = 1'b1;
`endif
    @(negedge clk);
    checks++;
    if (rd_data[XLEN +: XLEN] !== want_d) begin
      errors++; $display("FAIL bypass_data: got %h want %h", rd_data[XLEN +: XLEN], want_d);
    end
    checks++;
    if (rd_busy[1] !== want_b) begin
      errors++; $display("FAIL bypass_busy: got %b want %b", rd_busy[1], want_b);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (rd_data[XLEN +: XLEN] !== 32'h55 || rd_busy[1] !== 1'b0) begin
      errors++; $display("FAIL bypass_next: got %h/%b want 00000055/0", rd_data[XLEN +: XLEN], rd_busy[1]);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    iss_en = 1; iss_addr = 4;
    tick();
    idle();
    set_rd(0, 4);
    @(negedge clk);
    checks++;
    if (busy_vec[4] !== 1'b1 || rd_busy[0] !== 1'b1) begin
      errors++; $display("FAIL sb_issue: got vec=%b rd=%b want 1/1", busy_vec[4], rd_busy[0]);
    end
    wb_en = 1; wb_addr = 4; wb_data = 32'h99;
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (busy_vec[4] !== 1'b0 || rd_data[XLEN-1:0] !== 32'h99) begin
      errors++; $display("FAIL sb_clear: got vec=%b data=%h want 0/00000099", busy_vec[4], rd_data[XLEN-1:0]);
    end
    iss_en = 1; iss_addr = 4; wb_en = 1; wb_addr = 4; wb_data = 32'h77;
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (busy_vec[4] !== 1'b1) begin
      errors++; $display("FAIL sb_issue_beats_wb: got %b want 1", busy_vec[4]);
    end
  endtask

  task automatic test_flush();
    logic [NREGS-1:0] want;
    idle();
    iss_en = 1; iss_addr = 2;  tick();
    iss_addr = 6;              tick();
    iss_addr = 31;             tick();
    idle();
    @(negedge clk);
    checks++;
    if (busy_vec !== exp_vec()) begin
      errors++; $display("FAIL flush_pre: got %h want %h", busy_vec, exp_vec());
    end
    flush = 1; iss_en = 1; iss_addr = 8;
    tick();
    idle();
    want = '0;
    want[8] = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_vec !== want) begin
      errors++; $display("FAIL flush_with_issue: got %h want %h", busy_vec, want);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle();
      rst      = ($urandom_range(63) != 0);
      wa_en    = $urandom_range(1);
      wa_addr  = AW'($urandom_range(NREGS - 1));
      wa_data  = $urandom;
      wb_en    = $urandom_range(1);
      wb_addr  = ($urandom_range(3) == 0) ? wa_addr : AW'($urandom_range(NREGS - 1));
      wb_data  = $urandom;
      iss_en   = ($urandom_range(2) == 0);
      iss_addr = ($urandom_range(3) == 0) ? wb_addr : AW'($urandom_range(NREGS - 1));
      flush    = ($urandom_range(15) == 0);
      for (int k = 0; k < NREAD; k++) begin
        case ($urandom_range(3))
          0:       set_rd(k, wa_addr);
          1:       set_rd(k, wb_addr);
          default: set_rd(k, AW'($urandom_range(NREGS - 1)));
        endcase
      end
      @(negedge clk);
      for (int k = 0; k < NREAD; k++) begin
        checks++;
        if (rd_data[k*XLEN +: XLEN] !== exp_data(rd_addr[k*AW +: AW]) ||
            rd_busy[k] !== exp_busy(rd_addr[k*AW +: AW])) begin
          errors++;
          $display("FAIL rand_read c=%0d port=%0d addr=%0d: got %h/%b want %h/%b", c, k,
                   rd_addr[k*AW +: AW], rd_data[k*XLEN +: XLEN], rd_busy[k],
                   exp_data(rd_addr[k*AW +: AW]), exp_busy(rd_addr[k*AW +: AW]));
        end
      end
      checks++;
      if (busy_vec !== exp_vec()) begin
        errors++; $display("FAIL rand_busy_vec c=%0d: got %h want %h", c, busy_vec, exp_vec());
      end
      tick();
    end
    idle();
  endtask

  task automatic test_wide();
    logic [WAW-1:0]   addrs [WNREAD];
    logic [WXLEN-1:0] vals  [WNREAD];
    addrs[0] = 10; addrs[1] = 33; addrs[2] = 47; addrs[3] = 63;
    for (int k = 0; k < WNREAD; k++) vals[k] = {$urandom, $urandom};
    for (int p = 0; p < WNREAD; p += 2) begin
      w_wa_en = 1; w_wa_addr = addrs[p];     w_wa_data = vals[p];
      w_wb_en = 1; w_wb_addr = addrs[p + 1]; w_wb_data = vals[p + 1];
      tick();
    end
    w_wa_en = 0; w_wb_en = 0;
    for (int k = 0; k < WNREAD; k++) w_rd_addr[k*WAW +: WAW] = addrs[WNREAD - 1 - k];
    @(negedge clk);
    for (int k = 0; k < WNREAD; k++) begin
      checks++;
      if (w_rd_data[k*WXLEN +: WXLEN] !== vals[WNREAD - 1 - k]) begin
        errors++;
        $display("FAIL wide_port%0d: got %h want %h", k, w_rd_data[k*WXLEN +: WXLEN], vals[WNREAD - 1 - k]);
      end
    end
    checks++;
    if (w_busy_vec !== '0 || w_rd_busy !== '0) begin
      errors++; $display("FAIL wide_busy: got %h/%b want 0/0", w_busy_vec, w_rd_busy);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_bypass();
    test_scoreboard();
    test_flush();
    test_random();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file. Successor to the single-write, two-read register file in the RV32I core. Adds three things:
- configurable width, depth and read-port count;
- a second write port for late load writeback;
- a per-register busy scoreboard, so decode can stall on RAW hazards against in-flight loads.

It sits between decode (read/issue) and the two writeback stages (ALU/early, load/late).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >=2); register 0 hardwired to zero
NREAD, 2, number of independent combinational read ports (1..4)
AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-low reset
rd_addr  in  NREAD*AW  read addresses, port k at [k*AW +: AW]
rd_data  out  NREAD*XLEN  read data, port k at [k*XLEN +: XLEN]
rd_busy  out  NREAD  busy (pending load) flag for each read address
wa_en  in  1  write port A enable (ALU writeback)
wa_addr  in  AW  write port A address
wa_data  in  XLEN  write port A data
wb_en  in  1  write port B enable (load writeback)
wb_addr  in  AW  write port B address
wb_data  in  XLEN  write port B data
iss_en  in  1  issue of a load: mark iss_addr busy
iss_addr  in  AW  destination register of the issued load
flush  in  1  clear all busy bits (pipeline flush)
busy_vec  out  NREGS  registered scoreboard state, bit i = register i busy

Behaviour:
- Reset:
  - While rst==0 at a rising edge, all registers are cleared to 0 and all busy bits to 0.
  - rd_data reflects the zeroed state from the next cycle; busy_vec==0.
  - Reset overrides all writes, issue and flush in the same cycle.
- Register 0:
  - Reads always return 0 with rd_busy=0.
  - Writes to address 0 are discarded; iss_addr==0 is ignored.
- Writes: registered, one-cycle latency to the array. Both ports may write in the same cycle.
- Write collision: if wa_en && wb_en && wa_addr==wb_addr != 0, port A data is stored (port A carries the younger instruction); port B is dropped.
- Reads: combinational from the array, gated by bypass (see Optional Feature). Read ports are fully independent; duplicate addresses are legal.
- Scoreboard, per register i != 0, next-state priority:
  1. rst low -> 0;
  2. iss_en && iss_addr==i -> 1, even if flush or a write to i occurs the same cycle;
  3. flush -> 0;
  4. (wb_en && wb_addr==i) or (wa_en && wa_addr==i) -> 0;
  5. else hold.
- rd_busy[k]: busy_vec[rd_addr_k], masked to 0 when a same-cycle write to that address is bypassed (bypass build only).
- Without bypass, rd_busy[k] is the raw busy_vec bit.
- No width truncation: data passes through unchanged. Addresses >= NREGS cannot occur because NREGS is a power of two.

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined:
  - Write-to-read forwarding is active. rd_data[k] = wa_data if wa_en && wa_addr==rd_addr_k != 0; else wb_data if wb_en && wb_addr==rd_addr_k != 0; else the array value.
  - rd_busy[k] is masked as described in Behaviour.
- Undefined:
  - No forwarding. Reads return the array value only, so a write is visible one cycle after its write cycle.
  - rd_busy is unmasked.
  - The pipeline must then provide its own forwarding or stall.

Decomposition:
- Package regfile_pkg:
  - XLEN_DEF=32 and NREGS_DEF=32;
  - a function clog2;
  - a localparam ZERO_REG=0.
- One sub-module, rf_scoreboard, holds the NREGS busy flops, the issue/flush/clear priority logic and busy_vec.
- The data array, write arbitration and read/bypass muxes stay in regfile_mp.

Test Plan:
1. Reset: hold rst=0 two cycles with wa_en=1 wa_addr=5 wa_data=0xDEADBEEF -> after release, read x5 = 0 and busy_vec = 0.
2. Basic write/read: wa_en x3 = 0x12345678, next cycle rd_addr0=3 -> rd_data0 = 0x12345678. A write of 0xFFFFFFFF to x0 -> read x0 = 0.
3. Collision: wa x7 = 0xAAAA0000 and wb x7 = 0x0000BBBB in the same cycle -> next cycle x7 = 0xAAAA0000.
4. Bypass (macro defined): wb_en x9 = 0x55 while rd_addr1=9 in the same cycle -> rd_data1 = 0x55, rd_busy[1] = 0. With the macro undefined -> rd_data1 = old value, 0x55 appears next cycle.
5. Scoreboard:
   - iss x4 -> busy_vec[4] = 1 next cycle, rd_busy = 1 while read;
   - wb x4 = 0x99 -> busy clears the next cycle;
   - iss x4 and wb x4 in the same cycle -> busy stays 1.
6. Flush: busy x2, x6, x31, then flush=1 with iss x8 in the same cycle -> busy_vec = only bit 8 set. Run NREAD=4, NREGS=64, XLEN=64 with all four ports reading distinct written registers -> every port returns the correct data.
